// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports
// with write-to-read bypass, and a hardware clear sequencer that zeroes one entry per cycle.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_req,
  output logic                       busy,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic                       wconflict
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0]   regs [DEPTH];

  logic                wr_ok;
  logic                w0_zero, w1_zero;
  logic                same_addr;
  logic                wr0_en, wr1_en;
  logic                conflict;

  assign busy = (state == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Clear sequencer FSM
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch can be inferred.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    unique case (state)
      ST_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (clr_req) begin
          clr_cnt_nxt = '0;
          state_nxt   = ST_CLEAR;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write qualification: a clear request in RUN drops that cycle's writes
  // ---------------------------------------------------------------------------
  assign wr_ok     = (state == ST_RUN) && !clr_req;
  assign w0_zero   = (ZERO_REG != 0) && (waddr0 == '0);
  assign w1_zero   = (ZERO_REG != 0) && (waddr1 == '0);
  assign same_addr = (waddr0 == waddr1);

  // Port 1 is the younger instruction, so it wins a same-address collision.
  assign wr1_en   = wr_ok && we1 && !w1_zero;
  assign wr0_en   = wr_ok && we0 && !w0_zero && !(we1 && same_addr);
  assign conflict = wr_ok && we0 && we1 && same_addr && !w0_zero;

  // NOTE: the storage array has no reset term; the clear sequencer is what
  // initialises it, which keeps the array mappable onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      regs[clr_cnt] <= '0;
    end else begin
      if (wr0_en) regs[waddr0] <= wdata0;
      if (wr1_en) regs[waddr1] <= wdata1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wconflict <= 1'b0;
    else     wconflict <= conflict;
  end

  // ---------------------------------------------------------------------------
  // Read ports with bypass; port 1 data takes precedence over port 0
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd = '0;
      if (busy || !re[i]) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if (we1 && (waddr1 == ra)) begin
        rd = wdata1;
      end else if (we0 && (waddr0 == ra)) begin
        rd = wdata0;
      end else begin
        rd = regs[ra];
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expected values are queued when stimulus is
// driven and compared against the DUT when its outputs are sampled.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                     clk;
  logic                     rst;
  logic                     clr_req;
  logic                     busy;
  logic                     we0, we1;
  logic [ADDR_W-1:0]        waddr0, waddr1;
  logic [DATA_W-1:0]        wdata0, wdata1;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     wconflict;

  regfile_mp #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .we0      (we0),
    .waddr0   (waddr0),
    .wdata0   (wdata0),
    .we1      (we1),
    .waddr1   (waddr1),
    .wdata1   (wdata1),
    .re       (re),
    .raddr    (raddr),
    .rdata    (rdata),
    .wconflict(wconflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_RD0, K_RD1, K_BUSY, K_WCONF} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic push(input string tag, input kind_t k, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input kind_t k);
    case (k)
      K_RD0:   return rdata[0 +: DATA_W];
      K_RD1:   return rdata[DATA_W +: DATA_W];
      K_BUSY:  return {31'b0, busy};
      default: return {31'b0, wconflict};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.kind), e.val);
    end
  endtask

  initial begin
    rst     = 1'b1;
    clr_req = 1'b0;
    we0     = 1'b0;
    we1     = 1'b0;
    waddr0  = '0;
    waddr1  = '0;
    wdata0  = '0;
    wdata1  = '0;
    re      = 2'b11;
    raddr   = '0;

    // Reset held: busy, no conflict, reads forced to 0
    set_rd(5'd3, 5'd7);
    settle();
    push("rst_busy", K_BUSY, 32'd1);
    push("rst_wconf", K_WCONF, 32'd0);
    push("rst_rd0", K_RD0, 32'd0);
    push("rst_rd1", K_RD1, 32'd0);
    drain();
    tick();
    tick();
    rst = 1'b0;

    // Clear after reset release takes exactly DEPTH edges
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      settle();
      push($sformatf("init_busy_%0d", k), K_BUSY, (k < DEPTH) ? 32'd1 : 32'd0);
      push($sformatf("init_wconf_%0d", k), K_WCONF, 32'd0);
      drain();
    end

    for (int a = 0; a < DEPTH; a++) begin
      tick();
      set_rd(ADDR_W'(a), ADDR_W'(DEPTH - 1 - a));
      settle();
      push($sformatf("zero_rd0_a%0d", a), K_RD0, 32'd0);
      push($sformatf("zero_rd1_a%0d", a), K_RD1, 32'd0);
      push($sformatf("zero_wconf_a%0d", a), K_WCONF, 32'd0);
      drain();
    end

    // Dual write to distinct addresses
    tick();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1111_1111;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2222_2222;
    set_rd(5'd3, 5'd7);
    settle();
    push("dual_byp_rd0", K_RD0, 32'h1111_1111);
    push("dual_byp_rd1", K_RD1, 32'h2222_2222);
    drain();
    push("dual_arr_rd0", K_RD0, 32'h1111_1111);
    push("dual_arr_rd1", K_RD1, 32'h2222_2222);
    push("dual_wconf", K_WCONF, 32'd0);
    tick();
    we0 = 1'b0;
    we1 = 1'b0;
    settle();
    drain();

    // Same-address dual write: younger port wins and flags for one cycle
    tick();
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hAAAA_0000;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h0000_BBBB;
    set_rd(5'd9, 5'd7);
    settle();
    push("same_byp_rd0", K_RD0, 32'h0000_BBBB);
    push("same_wconf_pre", K_WCONF, 32'd0);
    drain();
    push("same_arr_rd0", K_RD0, 32'h0000_BBBB);
    push("same_arr_rd1", K_RD1, 32'h2222_2222);
    push("same_wconf", K_WCONF, 32'd1);
    tick();
    we0 = 1'b0;
    we1 = 1'b0;
    settle();
    drain();
    push("same_wconf_drop", K_WCONF, 32'd0);
    tick();
    settle();
    drain();

    // Same-address dual write to hardwired entry 0
    tick();
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h5555_5555;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h6666_6666;
    set_rd(5'd0, 5'd0);
    settle();
    push("zr_byp_rd0", K_RD0, 32'd0);
    push("zr_byp_rd1", K_RD1, 32'd0);
    drain();
    push("zr_arr_rd0", K_RD0, 32'd0);
    push("zr_wconf", K_WCONF, 32'd0);
    tick();
    we0 = 1'b0;
    we1 = 1'b0;
    settle();
    drain();

    // Read gating
    tick();
    re = 2'b01;
    set_rd(5'd0, 5'd3);
    settle();
    push("gate_rd0_addr0", K_RD0, 32'd0);
    push("gate_rd1_off", K_RD1, 32'd0);
    drain();
    re = 2'b10;
    settle();
    push("gate_rd1_on", K_RD1, 32'h1111_1111);
    drain();
    re = 2'b11;
    set_rd(5'd3, 5'd9);
    settle();
    push("gate_rd0_on", K_RD0, 32'h1111_1111);
    push("gate_rd1_r9", K_RD1, 32'h0000_BBBB);
    drain();

    // Port 0 bypass overrides a stale array value
    tick();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h3333_3333;
    set_rd(5'd7, 5'd3);
    settle();
    push("byp0_rd0", K_RD0, 32'h3333_3333);
    push("byp0_rd1", K_RD1, 32'h1111_1111);
    drain();
    push("byp0_arr_rd0", K_RD0, 32'h3333_3333);
    tick();
    we0 = 1'b0;
    settle();
    drain();

    // Clear request mid-run drops the concurrent write
    tick();
    clr_req = 1'b1;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
    settle();
    push("creq_busy_pre", K_BUSY, 32'd0);
    drain();
    tick();
    clr_req = 1'b0;
    we0     = 1'b0;
    set_rd(5'd5, 5'd7);
    for (int k = 0; k < DEPTH; k++) begin
      settle();
      push($sformatf("creq_busy_%0d", k), K_BUSY, 32'd1);
      push($sformatf("creq_rd0_%0d", k), K_RD0, 32'd0);
      drain();
      if (k == 20) begin
        we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hCAFE_F00D;
      end else begin
        we1 = 1'b0;
      end
      tick();
    end
    settle();
    push("creq_busy_done", K_BUSY, 32'd0);
    push("creq_rd0_a5", K_RD0, 32'd0);
    push("creq_rd1_a7", K_RD1, 32'd0);
    drain();
    tick();
    set_rd(5'd3, 5'd9);
    settle();
    push("creq_rd0_a3", K_RD0, 32'd0);
    push("creq_rd1_a9", K_RD1, 32'd0);
    drain();

    // Reset at clear cycle 10 restarts a full clear; writes while busy are ignored
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    rst = 1'b1;
    settle();
    push("mrst_busy", K_BUSY, 32'd1);
    push("mrst_wconf", K_WCONF, 32'd0);
    push("mrst_rd0", K_RD0, 32'd0);
    drain();
    tick();
    tick();
    rst = 1'b0;
    set_rd(5'd2, 5'd2);
    waddr0 = 5'd2;
    wdata0 = 32'hBADC_0DE5;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      settle();
      push($sformatf("mrst_busy_%0d", k), K_BUSY, (k < DEPTH) ? 32'd1 : 32'd0);
      if (k < DEPTH) push($sformatf("mrst_rd0_%0d", k), K_RD0, 32'd0);
      drain();
      we0 = (k >= 20 && k < DEPTH - 1);
    end
    tick();
    settle();
    push("mrst_after_rd0", K_RD0, 32'd0);
    push("mrst_after_rd1", K_RD1, 32'd0);
    push("mrst_after_busy", K_BUSY, 32'd0);
    drain();

    // Normal write accepted once the clear completes
    tick();
    we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h1234_5678;
    tick();
    we1 = 1'b0;
    settle();
    push("post_rd0", K_RD0, 32'h1234_5678);
    push("post_rd1", K_RD1, 32'h1234_5678);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the five-stage pipeline: 2 write ports, `NUM_RD` combinational read ports, and write-to-read bypass from both write ports. After reset, or on request, a built-in clear sequencer zeroes every entry in hardware, one entry per cycle. It sits between decode (reads) and write-back (writes), and serves as the drop-in next generation of the single-write register file for dual-issue work.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; `DEPTH = 2**ADDR_W` entries
- `NUM_RD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, 1 = entry 0 hardwired to zero; 0 = entry 0 is an ordinary register

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset; asynchronous and active-high
- `clr_req`  in  1  request a full clear sequence
- `busy`  out  1  clear sequence in progress
- `we0` / `we1`  in  1  write enables; port 1 is the younger instruction
- `waddr0` / `waddr1`  in  `ADDR_W`  write addresses
- `wdata0` / `wdata1`  in  `DATA_W`  write data
- `re`  in  `NUM_RD`  per-port read enable
- `raddr`  in  `NUM_RD*ADDR_W`  read addresses; port i at bits `[i*ADDR_W +: ADDR_W]`
- `rdata`  out  `NUM_RD*DATA_W`  read data; port i at bits `[i*DATA_W +: DATA_W]`, combinational
- `wconflict`  out  1  registered pulse: a same-address dual write occurred in the previous cycle

## Operation
- FSM states:
  - CLEAR: counter `clr_cnt` (`ADDR_W` bits) writes 0 to `regs[clr_cnt]` each cycle and increments.
    - When `clr_cnt == DEPTH-1`, go to RUN.
    - In CLEAR, `we0`, `we1` and `clr_req` are ignored.
  - RUN: normal operation.
    - `clr_req == 1` at an edge: `clr_cnt <= 0`, go to CLEAR, and drop the writes presented that cycle (clear has priority).
- `busy = (state == CLEAR)`.
- Writes, RUN only:
  - Each port whose `we` is high writes at the edge.
  - If `ZERO_REG` is set, a write to address 0 is discarded.
  - `we0 && we1 && waddr0 == waddr1`: port 1 data is stored; `wconflict` is set for the next cycle.
  - A conflict on address 0 with `ZERO_REG` set does not flag.
- Read port i priority, first match wins:
  1. `busy` → 0
  2. `re[i] == 0` → 0
  3. `raddr_i == 0 && ZERO_REG` → 0
  4. `we1 && waddr1 == raddr_i` → `wdata1`
  5. `we0 && waddr0 == raddr_i` → `wdata0`
  6. otherwise → `regs[raddr_i]`
- All read ports are independent; any ports may read the same address.
- The array itself has no reset term; the clear sequencer provides initialisation.

## Timing
- Async reset, while `rst` is high: state = CLEAR, `clr_cnt = 0`, `busy = 1`, `wconflict = 0`. `rdata` reads 0 via `busy`.
- After `rst` falls, the clear takes exactly `DEPTH` rising edges.
  - Edge k (1..DEPTH) clears entry k-1.
  - `busy` goes low after edge `DEPTH`.
  - The first accepted write is at edge `DEPTH+1`.
- `clr_req` is sampled in RUN.
  - `busy` goes high after that edge and stays high for `DEPTH` cycles.
  - No holes: the whole array reads 0 afterwards.
- Write latency is 1 edge. Bypass makes the written value visible on `rdata` in the same cycle it is presented.
- `wconflict` is high for exactly one cycle, the one after the conflicting edge. It is also cleared on any cycle where no conflict occurred.
- `rst` asserted mid-clear or mid-operation restarts the clear from entry 0. Contents written before reset are not guaranteed to survive.

## Test plan
- Reset release (`DEPTH=32`):
  - `busy` stays 1 for exactly 32 cycles, then 0.
  - All 32 addresses read 0 on every read port.
  - `wconflict` stays 0 throughout.
- Dual write to distinct addresses: `we0`/`waddr0=3`/`wdata0=0x11111111` and `we1`/`waddr1=7`/`wdata1=0x22222222`.
  - Same cycle: bypass shows both values on read ports reading 3 and 7.
  - Next cycle: array reads return 0x11111111 and 0x22222222.
- Same-address write: `waddr0 = waddr1 = 9`, `wdata0=0xAAAA0000`, `wdata1=0x0000BBBB`.
  - Bypass and later array read return 0x0000BBBB.
  - `wconflict` is 1 for one cycle.
  - Repeating the test at address 0 with `ZERO_REG=1` gives read 0 and `wconflict` stays 0.
- Read gating: `re[1] = 0` with `raddr1 = 3` → `rdata` port 1 = 0. `re[0] = 1` with `raddr0 = 0` → 0.
- `clr_req` mid-run:
  - Pulse `clr_req` while writing `0xDEADBEEF` to address 5; that write is dropped.
  - `busy` is high for 32 cycles.
  - After the clear, address 5 and address 7 both read 0.
- Reset mid-clear: assert `rst` at clear cycle 10, release → a full 32-cycle clear follows, and writes during `busy` are ignored.
